// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side control-flow bus between EX/fetch logic and pc_redirect_ctrl.
// Optional redirect statistics appear only when REDIRECT_STATS_EN is defined.
interface pc_redirect_ctrl_if;
  // Handshake: a fetch request transfers in a cycle where pc_valid && fetch_ready;
  // pc_out only advances sequentially on such a transfer, otherwise it holds.
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        branch_taken;
  logic        jalr_en;
  logic [31:0] jalr_target;
  logic        fetch_ready;

  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush;
  logic        misalign_exc;
  logic [31:0] exc_addr;
  logic [1:0]  dbg_state;

`ifdef REDIRECT_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] jalr_cnt;

  modport master (
    output ex_valid, ex_pc, ex_imm, branch_taken, jalr_en, jalr_target, fetch_ready,
    input  pc_out, pc_valid, flush, misalign_exc, exc_addr, dbg_state,
    input  branch_cnt, jalr_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_imm, branch_taken, jalr_en, jalr_target, fetch_ready,
    output pc_out, pc_valid, flush, misalign_exc, exc_addr, dbg_state,
    output branch_cnt, jalr_cnt
  );
`else
  modport master (
    output ex_valid, ex_pc, ex_imm, branch_taken, jalr_en, jalr_target, fetch_ready,
    input  pc_out, pc_valid, flush, misalign_exc, exc_addr, dbg_state
  );

  modport slave (
    input  ex_valid, ex_pc, ex_imm, branch_taken, jalr_en, jalr_target, fetch_ready,
    output pc_out, pc_valid, flush, misalign_exc, exc_addr, dbg_state
  );
`endif
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential advance, EX redirects with IF/ID flush bubbles, misaligned-target trap.
// Optional macro REDIRECT_STATS_EN adds saturating branch/JALR redirect counters.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  pc_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        redirect_w;
  logic [31:0] jalr_clr_w;
  logic [31:0] target_w;
  logic        target_misaligned_w;

  // Events are only honoured in RUN; anything arriving during FLUSH is being squashed.
  assign redirect_w          = (state_q == S_RUN) && bus.ex_valid && (bus.branch_taken || bus.jalr_en);
  assign jalr_clr_w          = bus.jalr_target & 32'hFFFF_FFFE;
  assign target_w            = bus.jalr_en ? jalr_clr_w : (bus.ex_pc + bus.ex_imm);
  assign target_misaligned_w = target_w[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect_w) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    pc_d        = pc_q;
    exc_addr_d  = exc_addr_q;
    misalign_d  = 1'b0;
    pc_valid_d  = (state_d == S_RUN);
    flush_d     = (state_d == S_FLUSH);
    if (redirect_w) begin
      if (target_misaligned_w) begin
        pc_d       = TRAP_VEC;
        exc_addr_d = target_w;
        misalign_d = 1'b1;
      end else begin
        pc_d       = target_w;
      end
    end else if ((state_q == S_RUN) && bus.fetch_ready) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      exc_addr_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_exc = misalign_q;
  assign bus.exc_addr     = exc_addr_q;
  assign bus.dbg_state    = state_q;

`ifdef REDIRECT_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] jalr_cnt_q, jalr_cnt_d;

  // Misaligned redirects count too; jalr_en wins when both kinds are flagged.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    jalr_cnt_d   = jalr_cnt_q;
    if (redirect_w) begin
      if (bus.jalr_en) begin
        if (jalr_cnt_q != 32'hFFFF_FFFF) jalr_cnt_d = jalr_cnt_q + 32'd1;
      end else begin
        if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      jalr_cnt_q   <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      jalr_cnt_q   <= jalr_cnt_d;
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
  assign bus.jalr_cnt   = jalr_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboarded bench for pc_redirect_ctrl: directed test-plan sequences plus random EX traffic.
module tb_pc_redirect_ctrl;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;
  localparam int          W            = 67;

  logic clk = 1'b0;
  logic rst;

  pc_redirect_ctrl_if bif();

  pc_redirect_ctrl #(
    .RESET_PC     (RESET_PC),
    .TRAP_VEC     (TRAP_VEC),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: a fetch engine that is either not yet started, fetching,
  // or sitting out a number of bubbles after a redirect.
  logic [31:0] m_pc;
  logic [31:0] m_exc;
  bit          m_started;
  bit          m_pulse;
  int          m_bubbles;
  int unsigned m_bcnt;
  int unsigned m_jcnt;

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_exc     = 32'd0;
    m_started = 1'b0;
    m_pulse   = 1'b0;
    m_bubbles = 0;
    m_bcnt    = 0;
    m_jcnt    = 0;
  endtask

  function automatic logic [W-1:0] model_outputs();
    logic pv, fl, mx;
    pv = m_started && (m_bubbles == 0);
    fl = (m_bubbles > 0);
    mx = m_pulse;
    return {pv, fl, mx, m_pc, m_exc};
  endfunction

  task automatic model_step(input bit ev, input bit bt, input bit jr, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] jt, input bit fr);
    logic [31:0] tgt;
    m_pulse = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_bubbles > 0) begin
      m_bubbles = m_bubbles - 1;
    end else if (ev && (bt || jr)) begin
      if (jr) begin
        tgt    = jt & 32'hFFFF_FFFE;
        m_jcnt = m_jcnt + 1;
      end else begin
        tgt    = pc + imm;
        m_bcnt = m_bcnt + 1;
      end
      if (tgt[1]) begin
        m_pc    = TRAP_VEC;
        m_exc   = tgt;
        m_pulse = 1'b1;
      end else begin
        m_pc = tgt;
      end
      m_bubbles = FLUSH_CYCLES;
    end else if (fr) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Driver: entered at posedge+1; records what this cycle must show, drives, advances one edge.
  task automatic cycle(input bit ev, input bit bt, input bit jr, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] jt, input bit fr);
    exp_q.push_back(model_outputs());
    bif.ex_valid     = ev;
    bif.branch_taken = bt;
    bif.jalr_en      = jr;
    bif.ex_pc        = pc;
    bif.ex_imm       = imm;
    bif.jalr_target  = jt;
    bif.fetch_ready  = fr;
    model_step(ev, bt, jr, pc, imm, jt, fr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit fr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, fr);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare on the falling edge.
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bif.pc_valid, bif.flush, bif.misalign_exc, bif.pc_out, bif.exc_addr};
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL trace t=%0t: pv/fl/mx/pc/exc got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                 $time, mon_act[66], mon_act[65], mon_act[64], mon_act[63:32], mon_act[31:0],
                 mon_exp[66], mon_exp[65], mon_exp[64], mon_exp[63:32], mon_exp[31:0]);
      end
    end
  end

  initial begin
    bif.ex_valid     = 1'b0;
    bif.branch_taken = 1'b0;
    bif.jalr_en      = 1'b0;
    bif.ex_pc        = 32'd0;
    bif.ex_imm       = 32'd0;
    bif.jalr_target  = 32'd0;
    bif.fetch_ready  = 1'b0;
    rst = 1'b1;
    #1;
    check32("reset_pc_out", bif.pc_out, RESET_PC);
    check32("reset_pc_valid", 32'(bif.pc_valid), 32'd0);
    check32("reset_flush", 32'(bif.flush), 32'd0);
    check32("reset_exc_addr", bif.exc_addr, 32'd0);
    do_reset();

    // Sequential fetch 0,4,8,C after the IDLE cycle
    idle(5, 1'b1);
    // Branch back to 0x30, second branch during FLUSH must be ignored
    cycle(1'b1, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFF0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h80, 32'h10, 32'd0, 1'b1);
    idle(3, 1'b1);
    // fetch_ready low holds pc_out
    idle(2, 1'b0);
    // JALR with bit0 set is aligned after clearing; bit1 set traps
    cycle(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'h0000_0205, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'h0000_0206, 1'b1);
    idle(3, 1'b1);
    // Both kinds flagged: JALR wins
    cycle(1'b1, 1'b1, 1'b1, 32'h1000, 32'h8, 32'h0000_0400, 1'b1);
    idle(3, 1'b1);
    // ex_valid low suppresses the event
    cycle(1'b0, 1'b1, 1'b1, 32'h1000, 32'h8, 32'h0000_0800, 1'b1);
    idle(1, 1'b1);
    // Wrap FFFF_FFFC -> 0
    cycle(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFD, 1'b1);
    idle(FLUSH_CYCLES, 1'b1);
    idle(3, 1'b1);

    // Random EX traffic
    for (int i = 0; i < 600; i++) begin
      bit ev, bt, jr, fr;
      logic [31:0] pc, imm, jt;
      ev  = ($urandom_range(0, 2) == 0);
      bt  = $urandom_range(0, 1);
      jr  = ($urandom_range(0, 3) == 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 2) != 0) ? ($urandom & 32'h0000_0FFC) : $urandom;
      jt  = $urandom;
      fr  = ($urandom_range(0, 3) != 0);
      cycle(ev, bt, jr, pc, imm, jt, fr);
    end
    idle(4, 1'b1);

`ifdef REDIRECT_STATS_EN
    check32("branch_cnt", bif.branch_cnt, m_bcnt);
    check32("jalr_cnt", bif.jalr_cnt, m_jcnt);
`endif

    // Reset asserted in the second FLUSH cycle takes effect immediately
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 32'h20, 32'd0, 1'b1);
    idle(1, 1'b1);
    check32("flush_before_rst", 32'(bif.flush), 32'd1);
    rst = 1'b1;
    #1;
    check32("async_rst_pc_out", bif.pc_out, RESET_PC);
    check32("async_rst_flush", 32'(bif.flush), 32'd0);
    check32("async_rst_pc_valid", 32'(bif.pc_valid), 32'd0);
    check32("async_rst_misalign", 32'(bif.misalign_exc), 32'd0);
`ifdef REDIRECT_STATS_EN
    check32("async_rst_branch_cnt", bif.branch_cnt, 32'd0);
`endif
    do_reset();
    idle(5, 1'b1);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-side consumer of the RV32IM ALU's control-flow outputs: Branch_taken, JALR_target and the JALR indication.
- Owns the architectural fetch PC and advances it sequentially.
- On a taken branch or JALR resolved in EX: loads the redirect target, flushes IF/ID for a fixed bubble count, then resumes fetch.
- Traps misaligned targets to a fixed vector.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch address on misaligned target.
- FLUSH_CYCLES, 2, bubbles inserted per redirect (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended branch offset.
- branch_taken  in  1  ALU Branch_taken.
- jalr_en  in  1  EX instruction is JALR.
- jalr_target  in  32  ALU JALR_target (rs1+imm).
- fetch_ready  in  1  instruction memory accepts pc_out this cycle.
- pc_out  out  32  fetch address.
- pc_valid  out  1  pc_out is a valid fetch request.
- flush  out  1  kill IF/ID contents.
- misalign_exc  out  1  one-cycle misaligned-target pulse.
- exc_addr  out  32  last offending target.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: pc_out=RESET_PC, pc_valid=0, flush=0, misalign_exc=0, exc_addr=0, state=IDLE, bubble counter=0.
- Reset asserted mid-operation (any state, including FLUSH) returns immediately to these values.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - The first rising edge with rst low moves to RUN.
  - pc_valid rises in RUN.
- RUN:
  - pc_valid=1.
  - If fetch_ready=1 and no redirect event: pc_out <= pc_out+4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
  - fetch_ready=0: pc_out holds.
- Redirect event (cycle N): state RUN & ex_valid & (branch_taken | jalr_en).
  - Target: jalr_en ? {jalr_target[31:1],1'b0} : ex_pc+ex_imm (32-bit wrap).
  - jalr_en has priority if both inputs are high.
  - The event overrides the sequential advance regardless of fetch_ready.
- Misaligned: target[1]==1 (no C extension).
  - pc_out <= TRAP_VEC.
  - exc_addr <= target.
  - misalign_exc=1 in cycle N+1 only.
- Normal redirect: pc_out <= target at edge N+1.
- Both redirect kinds: state <= FLUSH, counter <= FLUSH_CYCLES.
- FLUSH:
  - flush=1, pc_valid=0, pc_out held.
  - Counter decrements each cycle.
  - When the counter reaches 1, next state is RUN.
  - flush is high for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES).
  - pc_valid returns in cycle N+FLUSH_CYCLES+1 with the target address.
- Events during FLUSH are ignored, since those instructions are being flushed. ex_valid/branch_taken in FLUSH have no effect.
- flush, pc_valid and misalign_exc are all registered outputs; there is no combinational input-to-output path.
- Counter width is 4 bits.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined:
  - Adds outputs branch_cnt[31:0] and jalr_cnt[31:0].
  - Each counts accepted redirects of its kind, misaligned ones included.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
  - Ignored events are not counted.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, fetch_ready=1 for 4 cycles -> pc_out 0,4,8,C with pc_valid=1; flush=0 throughout.
- RUN, ex_valid=1, branch_taken=1, ex_pc=0x40, ex_imm=0xFFFF_FFF0 -> pc_out=0x30 next edge; flush=1 for 2 cycles; pc_valid=0 then 1 at 0x30.
- jalr_en=1, jalr_target=0x0000_0205 -> pc_out=0x204; misalign_exc stays 0. jalr_target=0x0000_0206 -> pc_out=0x100, misalign_exc one-cycle pulse, exc_addr=0x206.
- Second branch_taken asserted during FLUSH -> ignored: pc_out stays at first target, flush length unchanged; with REDIRECT_STATS_EN, branch_cnt increments by 1 only.
- rst asserted in second FLUSH cycle -> pc_out=RESET_PC, flush=0 and pc_valid=0 immediately (asynchronous), IDLE then RUN after release; pc_out=0xFFFF_FFFC with fetch_ready -> wraps to 0.
